// File: rtl/pause_pkg.sv
// pause_pkg -- shared types for the pause arbiter slice.
//   pause_state_e : arbiter FSM states (WAIT_VBL is only reachable when
//                   PAUSE_VBLANK_SYNC_EN is defined)
//   OPT_OSD/OPT_DIM : bit indices into the options input
package pause_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_VBL = 2'd1,
      PAUSED   = 2'd2,
      DIMMED   = 2'd3
   } pause_state_e;

   localparam int OPT_OSD = 0;
   localparam int OPT_DIM = 1;

endpackage

// File: rtl/pause_dim_timer.sv
// pause_dim_timer -- one-second prescaler feeding a saturating seconds counter.
//   clk_sys : clock, posedge
//   reset   : synchronous, active-high
//   run     : advance the prescaler this cycle
//   clear   : zero both counters (wins over run)
//   expired : seconds count has reached DIM_SECS, or reaches it at this edge
module pause_dim_timer
   import pause_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 24000000,
   parameter int unsigned DIM_SECS = 10
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int SW = $clog2(DIM_SECS + 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [SW-1:0] sec_q, sec_d;
   logic          tick;

   assign tick = run && (pre_q == PW'(CLK_HZ - 1));

   always_comb begin
      pre_d = pre_q;
      sec_d = sec_q;
      if (clear) begin
         pre_d = '0;
         sec_d = '0;
      end else if (run) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
         if (tick && sec_q != SW'(DIM_SECS))
            sec_d = sec_q + SW'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pre_q <= '0;
         sec_q <= '0;
      end else begin
         pre_q <= pre_d;
         sec_q <= sec_d;
      end
   end

   // Look ahead by one tick so the FSM leaves PAUSED on the very edge the
   // last second completes, instead of one cycle later.
   assign expired = (sec_q == SW'(DIM_SECS)) ||
                    (tick && sec_q == SW'(DIM_SECS - 1));

endmodule

// File: rtl/pause_arbiter.sv
// pause_arbiter -- merges user button, external requesters and OSD into one
// CPU pause, and dims the video after DIM_SECS seconds of idle pause.
//   clk_sys, reset          : clock / synchronous active-high reset
//   user_button             : level; rising edge toggles user pause or wakes
//   pause_request[NREQ]     : external requesters, OR-merged
//   options[1:0]            : [0] pause on OSD open, [1] dim enable
//   OSD_STATUS              : OSD open
//   vblank                  : core vblank (only with PAUSE_VBLANK_SYNC_EN)
//   rgb_in / rgb_out        : {r,g,b}, output registered with latency 1
//   pause_cpu, dim_active   : hold core / video currently dimmed
// Build option: PAUSE_VBLANK_SYNC_EN -- pause entry waits for a vblank rise.
module pause_arbiter
   import pause_pkg::*;
#(
   parameter int RW        = 3,
   parameter int GW        = 3,
   parameter int BW        = 2,
   parameter int NREQ      = 2,
   parameter int unsigned CLK_HZ   = 24000000,
   parameter int unsigned DIM_SECS = 10,
   parameter int DIM_SHIFT = 1
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   user_button,
   input  logic [NREQ-1:0]        pause_request,
   input  logic [1:0]             options,
   input  logic                   OSD_STATUS,
   input  logic                   vblank,
   input  logic [RW+GW+BW-1:0]    rgb_in,
   output logic [RW+GW+BW-1:0]    rgb_out,
   output logic                   pause_cpu,
   output logic                   dim_active
);

   localparam int CW = RW + GW + BW;

   pause_state_e  state_q, state_d;
   logic          btn_q;
   logic          user_pause_q, user_pause_d;
   logic [CW-1:0] rgb_q, rgb_d;
   logic          btn_rise, want;
   logic          tmr_run, tmr_clear, tmr_expired;

   assign btn_rise = user_button & ~btn_q;

   // In DIMMED the button only wakes the screen; it must not drop the pause.
   assign user_pause_d = (btn_rise && state_q != DIMMED) ? ~user_pause_q
                                                         : user_pause_q;

   // Uses the post-toggle user pause so a button press that coincides with
   // every other request dropping keeps the core paused.
   assign want = user_pause_d | (|pause_request) |
                 (options[OPT_OSD] & OSD_STATUS);

`ifdef PAUSE_VBLANK_SYNC_EN
   logic vbl_q, vbl_rise;
   assign vbl_rise = vblank & ~vbl_q;
   always_ff @(posedge clk_sys) begin
      if (reset) vbl_q <= 1'b0;
      else       vbl_q <= vblank;
   end
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
`endif

   always_comb begin
      state_d   = state_q;
      tmr_clear = 1'b0;
      case (state_q)
         RUN: begin
`ifdef PAUSE_VBLANK_SYNC_EN
            if (want) state_d = vbl_rise ? PAUSED : WAIT_VBL;
`else
            if (want) state_d = PAUSED;
`endif
         end
`ifdef PAUSE_VBLANK_SYNC_EN
         WAIT_VBL: begin
            if (!want)         state_d = RUN;
            else if (vbl_rise) state_d = PAUSED;
         end
`endif
         PAUSED: begin
            if (!want) begin
               state_d   = RUN;
               tmr_clear = 1'b1;
            end else if (options[OPT_DIM] && tmr_expired) begin
               state_d = DIMMED;
            end
         end
         DIMMED: begin
            if (!want) begin
               state_d   = RUN;
               tmr_clear = 1'b1;
            end else if (btn_rise || !options[OPT_DIM]) begin
               // Wake or dim disabled: back to PAUSED with a fresh timeout.
               state_d   = PAUSED;
               tmr_clear = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign tmr_run = (state_q == PAUSED) && options[OPT_DIM];

   pause_dim_timer #(
      .CLK_HZ   (CLK_HZ),
      .DIM_SECS (DIM_SECS)
   ) u_timer (
      .clk_sys (clk_sys),
      .reset   (reset),
      .run     (tmr_run),
      .clear   (tmr_clear),
      .expired (tmr_expired)
   );

   assign pause_cpu  = (state_q == PAUSED) || (state_q == DIMMED);
   assign dim_active = (state_q == DIMMED);

   always_comb begin
      rgb_d = rgb_in;
      if (dim_active)
         rgb_d = {rgb_in[CW-1 -: RW] >> DIM_SHIFT,
                  rgb_in[GW+BW-1 -: GW] >> DIM_SHIFT,
                  rgb_in[BW-1:0] >> DIM_SHIFT};
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= RUN;
         btn_q        <= 1'b0;
         user_pause_q <= 1'b0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         btn_q        <= user_button;
         user_pause_q <= user_pause_d;
         rgb_q        <= rgb_d;
      end
   end

   assign rgb_out = rgb_q;

endmodule
